// File: rtl/bin_to_bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq_pkg
// Description : Shared states and constants for the sequential BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
package bin_to_bcd_seq_pkg;

  localparam int c_BIN_WIDTH = 14;
  localparam int c_DIGITS    = 4;
  localparam int c_MAX_VALUE = 9999;
  localparam int c_NIB_W     = 4;
  localparam int c_CNT_W     = $clog2(c_BIN_WIDTH + 1);

  localparam logic [4*c_DIGITS-1:0] c_BCD_ERR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage : bin_to_bcd_seq_pkg
`default_nettype wire

// File: rtl/bin_to_bcd_seq_adjust.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adjust
// Description : Double-dabble nibble correction, adds 3 to digits of 5 or more.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [c_NIB_W-1:0] i_nibble,
  output logic [c_NIB_W-1:0] o_nibble
);

  // A digit of at most 9 plus 3 stays within 4 bits, so no carry is lost.
  assign o_nibble = (i_nibble >= c_NIB_W'(5)) ? (i_nibble + c_NIB_W'(3)) : i_nibble;

endmodule : bcd_digit_adjust
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : One-iteration-per-clock binary to packed BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_WIDTH = c_BIN_WIDTH,
  parameter int DIGITS    = c_DIGITS,
  parameter int MAX_VALUE = c_MAX_VALUE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  done,
  output logic                  busy,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  localparam logic [BIN_WIDTH-1:0] MAX_BIN = BIN_WIDTH'(MAX_VALUE);
  localparam logic [BCD_W-1:0]     BCD_ERR = {BCD_W{1'b1}};

  state_t               r_state;
  state_t               w_state_next;
  logic [SR_W-1:0]      r_shift;
  logic [SR_W-1:0]      w_adj;
  logic [CNT_W-1:0]     r_cnt;
  logic [BCD_W-1:0]     r_bcd;
  logic                 r_done;
  logic                 r_busy;
  logic                 r_ovf;
  logic                 w_in_range;

  assign w_in_range = (bin_in <= MAX_BIN);

  // Binary field passes through untouched; only the BCD digits are corrected.
  assign w_adj[BIN_WIDTH-1:0] = r_shift[BIN_WIDTH-1:0];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_adjust u_adjust (
        .i_nibble (r_shift[BIN_WIDTH+4*gi +: 4]),
        .o_nibble (w_adj[BIN_WIDTH+4*gi +: 4])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = w_in_range ? CONV : FINISH;
        end
      end
      CONV: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = FINISH;
        end
      end
      FINISH: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (w_in_range) begin
              r_shift <= {{BCD_W{1'b0}}, bin_in};
              r_cnt   <= CNT_W'(BIN_WIDTH);
              r_ovf   <= 1'b0;
            end else begin
              r_ovf   <= 1'b1;
            end
          end
        end
        CONV: begin
          r_shift <= w_adj << 1;
          r_cnt   <= r_cnt - CNT_W'(1);
        end
        FINISH: begin
          // Display only ever sees a finished result or the error pattern.
          r_bcd  <= r_ovf ? BCD_ERR : r_shift[SR_W-1 -: BCD_W];
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bcd_out  = r_bcd;
  assign done     = r_done;
  assign busy     = r_busy;
  assign overflow = r_ovf;

endmodule : bin_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_seq
// Description : Self-checking bench for bin_to_bcd_seq with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin_in;
  logic [15:0] bcd_out;
  logic        done;
  logic        busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  bin_to_bcd_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .bcd_out  (bcd_out),
    .done     (done),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Transaction-level model: a conversion takes a fixed number of cycles.
  bit          model_on = 1'b0;
  bit          m_busy, m_done, m_ovf;
  logic [15:0] m_bcd, m_pend;
  int          m_rem;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_ovf = 0; m_bcd = '0; m_pend = '0; m_rem = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      m_done = 0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0;
          m_done = 1;
          m_bcd  = m_pend;
        end
      end else if (start) begin
        m_busy = 1;
        if (int'(bin_in) > 9999) begin
          m_ovf = 1; m_pend = 16'hFFFF; m_rem = 1;
        end else begin
          m_ovf = 0; m_pend = to_bcd(int'(bin_in)); m_rem = 15;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (model_on) begin
      check("bcd_out", bcd_out, m_bcd);
      check("done", done, m_done);
      check("busy", busy, m_busy);
      check("overflow", overflow, m_ovf);
    end
  end

  task automatic wait_done(input int limit, output int cycles, output bit ok);
    cycles = 0;
    ok = 0;
    while (cycles < limit && !ok) begin
      @(posedge clk); #1;
      cycles++;
      if (done) ok = 1;
    end
  endtask

  task automatic conv(input int v, input logic [15:0] exp, input int lat, input bit ovf);
    int cyc;
    bit ok;
    @(negedge clk);
    start = 1; bin_in = 14'(v);
    @(posedge clk); #1;
    start = 0;
    check("busy_after_accept", busy, 1);
    wait_done(40, cyc, ok);
    check("done_seen", ok, 1);
    check("latency", cyc, lat);
    check("result", bcd_out, exp);
    check("ovf_flag", overflow, ovf);
    check("busy_in_done", busy, 0);
    @(posedge clk); #1;
    check("done_single", done, 0);
  endtask

  initial begin
    int cyc;
    bit ok;
    int n_done;
    reset = 1; start = 0; bin_in = '0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    check("rst_bcd", bcd_out, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);

    conv(1234, 16'h1234, 15, 0);
    conv(0,    16'h0000, 15, 0);
    conv(9,    16'h0009, 15, 0);
    conv(10,   16'h0010, 15, 0);
    conv(999,  16'h0999, 15, 0);
    conv(9999, 16'h9999, 15, 0);
    conv(10000, 16'hFFFF, 1, 1);
    conv(42,   16'h0042, 15, 0);

    // Held start: second job accepted in the done cycle, bin_in changed mid-run.
    @(negedge clk);
    start = 1; bin_in = 14'd5678;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1 bin_in = 14'd1111;
    wait_done(40, cyc, ok);
    check("b2b_first_seen", ok, 1);
    check("b2b_first_lat", cyc, 10);
    check("b2b_first_val", bcd_out, 16'h5678);
    wait_done(40, cyc, ok);
    start = 0;
    check("b2b_second_seen", ok, 1);
    check("b2b_period", cyc, 16);
    check("b2b_second_val", bcd_out, 16'h1111);
    @(posedge clk); #1;
    check("b2b_idle_busy", busy, 0);

    conv(1234, 16'h1234, 15, 0);
    @(negedge clk);
    start = 1; bin_in = 14'd4321;
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("abort_bcd", bcd_out, 16'h0000);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    n_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    @(negedge clk);
    reset = 1; start = 1; bin_in = 14'd100;
    @(posedge clk); #1;
    reset = 0; start = 0;
    check("rst_start_busy", busy, 0);
    @(posedge clk); #1;
    check("rst_start_idle", busy, 0);
    check("rst_start_nodone", done, 0);

    // Randomised traffic including starts while busy and rare resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0:       bin_in = 14'($urandom_range(10000, 16383));
        1:       bin_in = 14'($urandom_range(9998, 10001));
        2:       bin_in = 14'($urandom_range(0, 10));
        default: bin_in = 14'($urandom_range(0, 9999));
      endcase
      reset = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    start = 0; reset = 0;
    repeat (30) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bin_to_bcd_seq
`default_nettype wire

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential shift-add-3 (double-dabble) converter that turns a 14-bit binary count (0..9999) into four packed BCD nibbles.
- Sits directly upstream of the four-digit seven-segment display driver.
- bcd_out connects to the driver's input_value; done connects to its start_signal.
- Runs in the 12 MHz system clock domain. Conversion uses one iteration per clock, so no wide combinational divider is needed.

Parameters:
BIN_WIDTH, 14, width of binary input; iteration count per conversion
DIGITS, 4, number of BCD output nibbles (output width 4*DIGITS)
MAX_VALUE, 9999, largest convertible value; above this is an overflow

Ports:
clk  input  1  system clock, 12 MHz, rising-edge
reset  input  1  synchronous, active-high reset
start  input  1  request conversion of bin_in; sampled only in IDLE
bin_in  input  BIN_WIDTH  binary value to convert
bcd_out  output  4*DIGITS  packed BCD result, digit 3 in [15:12] down to digit 0 in [3:0]
done  output  1  one-cycle pulse: bcd_out updated this cycle
busy  output  1  high while a conversion is in progress
overflow  output  1  high when the last accepted bin_in exceeded MAX_VALUE; held until the next accepted start

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). Reset has priority over every other event, including start in the same cycle.
- Reset values: bcd_out=16'h0000, done=0, busy=0, overflow=0, state=IDLE, shift register=0, iteration counter=0.
- States:
  - IDLE: waits for start.
  - CONV: iterates.
  - FINISH: registers the result and pulses done.
- IDLE, start=1 at edge k:
  - If bin_in <= MAX_VALUE: capture bin_in into the low BIN_WIDTH bits of a (4*DIGITS+BIN_WIDTH)-bit shift register with the BCD part zeroed; load counter=BIN_WIDTH; overflow<=0; go to CONV.
  - Otherwise: overflow<=1, go to FINISH directly, and force the result to 16'hFFFF (the display shows "FFFF" as the error indication).
- IDLE, start=0: stay in IDLE; all outputs hold.
- CONV, each edge:
  - Every BCD nibble >=5 gets +3 (all nibbles in parallel).
  - Then the whole register shifts left by 1 and counter decrements.
  - When counter reaches 1 at an edge, the final iteration is done that edge and the next state is FINISH.
- FINISH, one cycle:
  - bcd_out <= BCD field (or 16'hFFFF on overflow).
  - done is high during the cycle after this edge, then returns to IDLE.
- Latency:
  - start sampled at edge k → bcd_out valid and done=1 after edge k+BIN_WIDTH+1 (k+15 by default).
  - Overflow path → done after edge k+1.
- busy=1 from after edge k until the FINISH edge, so busy and done are never high together.
- start while busy: ignored, not queued.
- start high in the done cycle: the FSM is in IDLE then, so it is accepted (back-to-back conversions every BIN_WIDTH+2 cycles).
- bcd_out holds the previous result throughout a conversion (no intermediate values visible to the display). It changes only at the FINISH edge or on reset.
- bin_in is sampled only at acceptance; later changes do not affect an ongoing conversion.
- Reset mid-conversion: aborts immediately, all outputs to reset values, no done pulse.
- Arithmetic: each nibble adjust is 4-bit, and no carry leaves a nibble (values <=4 after shift guarantee this). Values 0..9999 fit exactly in four digits.

Decomposition:
- Shared package holds:
  - state enum IDLE/CONV/FINISH;
  - constants BCD_ERR=16'hFFFF, MAX_VALUE, DIGITS, BIN_WIDTH defaults;
  - the counter width derived as clog2(BIN_WIDTH+1).
- One natural combinational sub-module, bcd_digit_adjust: 4-bit in → 4-bit out (+3 if >=5). It is instantiated DIGITS times via generate.

Test Plan:
- Reset held 3 cycles, then start with bin_in=1234 → busy=1 for 15 cycles; after edge k+15, bcd_out=16'h1234, done=1 for exactly one cycle, overflow=0.
- Corner values 0, 9, 10, 999, 9999 converted in sequence → bcd_out 16'h0000, 16'h0009, 16'h0010, 16'h0999, 16'h9999 respectively, each with a single done pulse.
- bin_in=10000 → overflow=1, bcd_out=16'hFFFF, done pulse after edge k+1. Then bin_in=42 → overflow=0, bcd_out=16'h0042.
- start=1 held continuously with bin_in=5678, changed to 1111 mid-conversion:
  - first result is 16'h5678;
  - the next conversion is accepted in the done cycle and yields 16'h1111;
  - the period between done pulses is 16 cycles.
- Conversion of 4321 after an earlier result of 16'h1234; reset asserted 7 cycles in → no done pulse, bcd_out=16'h0000 and busy=0 the cycle after reset. Start and reset asserted together → stays IDLE.
- End-to-end: connect to the display driver, convert 2024 → driver's current_nibble sequence over digit scans reads 4,2,0,2 for digits 0..3.
